// File: rtl/booth_radix4_multiplier_pkg.sv
// Shared types for the radix-4 Booth multiplier.
//   state_t     : controller states
//   digit_t     : recoded radix-4 Booth digit
//   iter_count  : radix-4 steps needed for an N-bit operand (N/2+1)
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_ITER,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_t;

    // Operands are extended to N+2 bits, i.e. (N+2)/2 digit windows.
    function automatic int unsigned iter_count(input int unsigned n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_radix4_multiplier_if.sv
// Operand/result handshake bundle of the radix-4 Booth multiplier.
//   master (controller) drives : load, recieved, is_signed, A, B
//   slave  (multiplier) drives : busy, init, done, C
interface booth_radix4_multiplier_if #(
    parameter int unsigned N = 32
);

    logic             load;
    logic             recieved;
    logic             is_signed;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic             busy;
    logic             init;
    logic             done;
    logic [2*N-1:0]   C;

    modport master (
        output load, recieved, is_signed, A, B,
        input  busy, init, done, C
    );

    modport slave (
        input  load, recieved, is_signed, A, B,
        output busy, init, done, C
    );

endinterface

// File: rtl/booth_radix4_multiplier_recoder.sv
// Radix-4 Booth recoder: turns a 3-bit window {Q[1],Q[0],Q_1} and the
// extended multiplicand into a signed partial product.
//   win   : {Q[1], Q[0], Q_1}
//   mx    : multiplicand, N+2 bits, already sign/zero extended
//   pp_c  : digit * mx, N+4 bits signed (combinational)
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [2:0]          win,
    input  logic signed [N+1:0] mx,
    output logic signed [N+3:0] pp_c
);

    digit_t              digit;
    logic signed [N+3:0] mx_ext;

    // Window to digit
    always_comb begin
        digit = ZERO;
        case (win)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

    // Digit to partial product; two guard bits keep +/-2Mx in range
    always_comb begin
        mx_ext = {{2{mx[N+1]}}, mx};
        pp_c   = '0;
        case (digit)
            POS1:    pp_c = mx_ext;
            POS2:    pp_c = mx_ext <<< 1;
            NEG1:    pp_c = -mx_ext;
            NEG2:    pp_c = -(mx_ext <<< 1);
            default: pp_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation.
// Retires two multiplier bits per cycle; result valid ITER+2 cycles after
// load is sampled.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of booth_radix4_multiplier_if
//         in  load, recieved, is_signed, A, B
//         out busy, init, done, C (all registered)
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    booth_radix4_multiplier_if.slave  bus
);

    localparam int unsigned ITER  = iter_count(N);
    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned AW    = N + 4;
    localparam int unsigned QW    = N + 2;

    if ((N % 2) != 0 || N < 4) begin : g_bad_width
        $fatal(1, "booth_radix4_multiplier: N must be even and >= 4");
    end

    state_t                state_q, state_d;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  pp_c;
    logic signed [AW-1:0]  sum_c;
    logic signed [QW-1:0]  mx_q;
    logic [QW-1:0]         q_q;
    logic                  q_1_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q;
    logic                  init_q;
    logic                  done_q;
    logic [2*N-1:0]        c_q;

    booth_r4_recoder #(.N(N)) u_recoder (
        .win  ({q_q[1], q_q[0], q_1_q}),
        .mx   (mx_q),
        .pp_c (pp_c)
    );

    assign sum_c = acc_q + pp_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state; DONE is only left once the result has been published
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.load) state_d = ST_INIT;
            ST_INIT: state_d = ST_ITER;
            ST_ITER: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: if (done_q && bus.recieved) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            mx_q   <= '0;
            q_q    <= '0;
            q_1_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            init_q <= 1'b0;
            done_q <= 1'b0;
            c_q    <= '0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            init_q <= (state_q == ST_INIT);
            case (state_q)
                ST_INIT: begin
                    mx_q  <= bus.is_signed ? {{2{bus.A[N-1]}}, bus.A} : {2'b00, bus.A};
                    q_q   <= bus.is_signed ? {{2{bus.B[N-1]}}, bus.B} : {2'b00, bus.B};
                    acc_q <= '0;
                    q_1_q <= 1'b0;
                    cnt_q <= CNT_W'(ITER - 1);
                end
                ST_ITER: begin
                    // Arithmetic shift right by 2 of {ACC+pp, Q, Q_1}
                    acc_q <= {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
                    q_q   <= {sum_c[1:0], q_q[QW-1:2]};
                    q_1_q <= q_q[1];
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_DONE: begin
                    // First DONE cycle publishes the product
                    if (!done_q) begin
                        c_q    <= {acc_q[N-3:0], q_q};
                        done_q <= 1'b1;
                    end else if (bus.recieved) begin
                        done_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.init = init_q;
    assign bus.done = done_q;
    assign bus.C    = c_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier: an N=32 instance for the
// directed cases and an N=8 instance for a corner/random sweep. Expected
// products come from native multiplication and flow through scoreboards.
module tb_booth_radix4_multiplier;

    logic clk;
    logic rst32;
    logic rst8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb32[$];
    logic [15:0] sb8[$];

    booth_radix4_multiplier_if #(.N(32)) b32 ();
    booth_radix4_multiplier_if #(.N(8))  b8  ();

    booth_radix4_multiplier #(.N(32)) dut32 (.clk(clk), .rst(rst32), .bus(b32));
    booth_radix4_multiplier #(.N(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model32(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint ea, eb;
        ea = s ? longint'($signed(a)) : longint'(a);
        eb = s ? longint'($signed(b)) : longint'(b);
        return 64'(ea * eb);
    endfunction

    function automatic logic [15:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int ea, eb;
        ea = s ? int'($signed(a)) : int'(a);
        eb = s ? int'($signed(b)) : int'(b);
        return 16'(ea * eb);
    endfunction

    // ---------------- N=32 helpers ----------------
    task automatic start32(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        b32.is_signed = s;
        b32.A         = a;
        b32.B         = b;
        b32.load      = 1'b1;
        sb32.push_back(model32(s, a, b));
        @(posedge clk);
        #1 b32.load = 1'b0;
    endtask

    // Counts edges after the load edge until done; optionally disturbs inputs
    task automatic wait_done32(output int cyc, output int init_cnt, output int init_cyc,
                               input logic disturb);
        cyc = 0; init_cnt = 0; init_cyc = -1;
        while (b32.done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
            if (b32.init === 1'b1) begin
                init_cnt++;
                if (init_cyc < 0) init_cyc = cyc;
            end
            if (disturb && cyc >= 2) begin
                b32.load      = 1'b1;
                b32.recieved  = 1'b1;
                b32.A         = $urandom;
                b32.B         = $urandom;
                b32.is_signed = ~b32.is_signed;
            end
        end
        b32.load     = 1'b0;
        b32.recieved = 1'b0;
    endtask

    task automatic pop_check32(input string tag);
        logic [63:0] e;
        check({tag, "_done"}, 64'(b32.done), 64'd1);
        if (sb32.size() == 0) begin
            check({tag, "_sb"}, 64'd0, 64'd1);
        end else begin
            e = sb32.pop_front();
            check(tag, b32.C, e);
        end
    endtask

    task automatic ack32(input string tag);
        @(negedge clk);
        b32.recieved = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ack_done"}, 64'(b32.done), 64'd0);
        check({tag, "_ack_busy"}, 64'(b32.busy), 64'd0);
        b32.recieved = 1'b0;
    endtask

    // ---------------- N=8 helpers ----------------
    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int cyc;
        logic [15:0] e;
        @(negedge clk);
        b8.is_signed = s;
        b8.A         = a;
        b8.B         = b;
        b8.load      = 1'b1;
        sb8.push_back(model8(s, a, b));
        @(posedge clk);
        #1 b8.load = 1'b0;
        cyc = 0;
        while (b8.done !== 1'b1 && cyc < 50) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (cyc != 7) check("n8_latency", 64'(cyc), 64'd7);
        e = sb8.pop_front();
        check($sformatf("n8_%0d_%02h_%02h", s, a, b), 64'(b8.C), 64'(e));
        @(negedge clk);
        b8.recieved = 1'b1;
        @(posedge clk);
        #1 b8.recieved = 1'b0;
    endtask

    initial begin
        int cyc, ic, icyc;
        logic [63:0] hold_c;
        logic [7:0] corners [8];

        b32.load = 0; b32.recieved = 0; b32.is_signed = 0; b32.A = '0; b32.B = '0;
        b8.load  = 0; b8.recieved  = 0; b8.is_signed  = 0; b8.A  = '0; b8.B  = '0;
        rst32 = 1'b1;
        rst8  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(b32.busy), 64'd0);
        check("rst_init", 64'(b32.init), 64'd0);
        check("rst_done", 64'(b32.done), 64'd0);
        check("rst_c",    b32.C,         64'd0);
        check("rst_c8",   64'(b8.C),     64'd0);
        rst32 = 1'b0;
        rst8  = 1'b0;

        // Signed -1 x -1: latency and init pulse
        start32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32(cyc, ic, icyc, 1'b0);
        check("lat_signed", 64'(cyc), 64'd19);
        check("init_count", 64'(ic), 64'd1);
        check("init_cycle", 64'(icyc), 64'd1);
        check("s_m1xm1_const", b32.C, 64'h0000_0000_0000_0001);
        pop_check32("s_m1xm1");
        ack32("s_m1xm1");

        // Unsigned max x max, then hold recieved low
        start32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32(cyc, ic, icyc, 1'b0);
        check("lat_unsigned", 64'(cyc), 64'd19);
        check("u_max_const", b32.C, 64'hFFFF_FFFE_0000_0001);
        hold_c = 64'hFFFF_FFFE_0000_0001;
        pop_check32("u_max");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_done_%0d", i), 64'(b32.done), 64'd1);
            check($sformatf("hold_c_%0d", i), b32.C, hold_c);
        end
        ack32("u_max");

        start32(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done32(cyc, ic, icyc, 1'b0);
        check("s_min_sq_const", b32.C, 64'h4000_0000_0000_0000);
        pop_check32("s_min_sq");
        ack32("s_min_sq");

        // Inputs, load and recieved toggled while busy must not matter
        start32(1'b1, 32'h8000_0000, 32'h0000_0001);
        wait_done32(cyc, ic, icyc, 1'b1);
        check("lat_disturb", 64'(cyc), 64'd19);
        check("s_min_x1_const", b32.C, 64'hFFFF_FFFF_8000_0000);
        pop_check32("s_min_x1");
        ack32("s_min_x1");

        // Reset on the 5th ITER cycle abandons the operation
        start32(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(posedge clk);
        #1 rst32 = 1'b1;
        void'(sb32.pop_back());
        @(posedge clk);
        #1;
        check("mid_rst_busy", 64'(b32.busy), 64'd0);
        check("mid_rst_init", 64'(b32.init), 64'd0);
        check("mid_rst_done", 64'(b32.done), 64'd0);
        check("mid_rst_c",    b32.C,         64'd0);
        rst32 = 1'b0;
        start32(1'b1, 32'd7, 32'hFFFF_FFFD);
        wait_done32(cyc, ic, icyc, 1'b0);
        check("post_rst_lat", 64'(cyc), 64'd19);
        check("s_7xm3_const", b32.C, 64'hFFFF_FFFF_FFFF_FFEB);
        pop_check32("s_7xm3");
        ack32("s_7xm3");

        // Random N=32 operations in both modes
        for (int i = 0; i < 20; i++) begin
            start32(1'(i & 1), $urandom, $urandom);
            wait_done32(cyc, ic, icyc, 1'b0);
            pop_check32($sformatf("rand32_%0d", i));
            ack32("rand32");
        end

        // N=8: all corner pairs in both modes plus random pairs
        corners = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    run8(1'(s), corners[i], corners[j]);
        for (int i = 0; i < 400; i++)
            run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
